// File: rtl/valve_pkg.sv
// Shared state encoding and parameter defaults for the irrigation valve driver.
package valve_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OPENING  = 3'd1,
        ST_WATERING = 3'd2,
        ST_CLOSING  = 3'd3,
        ST_COOLDOWN = 3'd4,
        ST_FAULT    = 3'd5
    } valve_state_e;

    localparam int DEB_TICKS_DEF     = 3;
    localparam int MAX_ON_TICKS_DEF  = 60;
    localparam int MIN_OFF_TICKS_DEF = 30;
    localparam int ACK_CYCLES_DEF    = 8;

endpackage

// File: rtl/tick_debouncer.sv
// Counts consecutive ticks with din=1, saturating at DEB_TICKS; any tick with din=0 clears.
module tick_debouncer
    import valve_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic clk,
    input  logic clear_n,
    input  logic tick,
    input  logic din,
    output logic ok
);

    localparam int W = (DEB_TICKS < 1) ? 1 : $clog2(DEB_TICKS + 1);
    localparam logic [W-1:0] CNT_MAX = W'(DEB_TICKS);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            if (!din) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ok = (cnt_q == CNT_MAX);

endmodule

// File: rtl/valve_jk_driver.sv
// Watering controller: debounced dry sensor opens the valve via a one-cycle j pulse,
// closes it via a one-cycle k pulse, and enforces on-time, rest-time and feedback checks.
module valve_jk_driver
    import valve_pkg::*;
#(
    parameter int DEB_TICKS     = DEB_TICKS_DEF,
    parameter int MAX_ON_TICKS  = MAX_ON_TICKS_DEF,
    parameter int MIN_OFF_TICKS = MIN_OFF_TICKS_DEF,
    parameter int ACK_CYCLES    = ACK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       tick,
    input  logic       dry,
    input  logic       tank_low,
    input  logic       q_fb,
    output logic       j,
    output logic       k,
    output logic [2:0] state,
    output logic       fault
);

    localparam int TMR_MAX_A = (MAX_ON_TICKS > MIN_OFF_TICKS) ? MAX_ON_TICKS : MIN_OFF_TICKS;
    localparam int TMR_MAX   = (TMR_MAX_A > ACK_CYCLES) ? TMR_MAX_A : ACK_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(MAX_ON_TICKS - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(MIN_OFF_TICKS - 1);
    localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_CYCLES - 1);

    valve_state_e     state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             fault_q, fault_d;
    logic             dry_ok;
    logic             deb_din;

    // Dry is masked during COOLDOWN: it is ignored there, and the tick that ends
    // COOLDOWN also clears the debounce count, so a fresh debounce is needed after rest.
    assign deb_din = dry & (state_q != ST_COOLDOWN);

    tick_debouncer #(
        .DEB_TICKS(DEB_TICKS)
    ) u_deb (
        .clk    (clk),
        .clear_n(clear_n),
        .tick   (tick),
        .din    (deb_din),
        .ok     (dry_ok)
    );

    // One timer serves the ack window, the on-time and the rest time; it is zeroed on every entry.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dry_ok && !tank_low) begin
                    state_d = ST_OPENING;
                    tmr_d   = '0;
                    j_d     = 1'b1;
                end
            end
            ST_OPENING: begin
                if (q_fb) begin
                    state_d = ST_WATERING;
                    tmr_d   = '0;
                end else if (tmr_q == ACK_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WATERING: begin
                if (!q_fb) begin
                    state_d = ST_FAULT;
                end else if (!dry || tank_low || (tick && (tmr_q == ON_LAST))) begin
                    state_d = ST_CLOSING;
                    tmr_d   = '0;
                    k_d     = 1'b1;
                end else if (tick) begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_CLOSING: begin
                if (!q_fb) begin
                    state_d = ST_COOLDOWN;
                    tmr_d   = '0;
                end else if (tmr_q == ACK_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (tmr_q == OFF_LAST) begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        // FAULT drives the valve closed for as long as it lasts.
        if (state_d == ST_FAULT) begin
            j_d     = 1'b0;
            k_d     = 1'b1;
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            j_q     <= j_d;
            k_q     <= k_d;
            fault_q <= fault_d;
        end
    end

    assign j     = j_q;
    assign k     = k_q;
    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_valve_jk_driver.sv
// Directed bench for valve_jk_driver with a behavioural downstream JK flip-flop on q_fb.
module tb_valve_jk_driver;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       tick;
    logic       dry;
    logic       tank_low;
    logic       q_fb;
    logic       j;
    logic       k;
    logic [2:0] state;
    logic       fault;

    logic vq    = 1'b0;
    logic stuck = 1'b0;
    int   j_cnt   = 0;
    int   k_cnt   = 0;
    int   jk_both = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   j0;
    int   k0;

    valve_jk_driver dut (
        .clk     (clk),
        .clear_n (clear_n),
        .tick    (tick),
        .dry     (dry),
        .tank_low(tank_low),
        .q_fb    (q_fb),
        .j       (j),
        .k       (k),
        .state   (state),
        .fault   (fault)
    );

    // clock / valve model / pulse counters
    always #5 clk = ~clk;

    assign q_fb = stuck ? 1'b0 : vq;

    always @(posedge clk) begin
        if (j) vq <= 1'b1;
        else if (k) vq <= 1'b0;
        if (j) j_cnt <= j_cnt + 1;
        if (k) k_cnt <= k_cnt + 1;
        if (j && k) jk_both <= jk_both + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic tick_until(input string tag, input logic [2:0] want, input int budget);
        int n = 0;
        while (state !== want && n < budget) begin
            do_tick();
            n++;
        end
        check(tag, {29'd0, state}, {29'd0, want});
    endtask

    initial begin
        clear_n = 1'b0; tick = 1'b0; dry = 1'b0; tank_low = 1'b0;
        repeat (3) step();
        check("rst_state", {29'd0, state}, 0);
        check("rst_j", {31'd0, j}, 0);
        check("rst_k", {31'd0, k}, 0);
        check("rst_fault", {31'd0, fault}, 0);
        clear_n = 1'b1;
        step();
        check("post_rst_state", {29'd0, state}, 0);

        // nominal cycle
        j0 = j_cnt; k0 = k_cnt;
        dry = 1'b1;
        repeat (3) do_tick();
        check("nom_debounced_idle", {29'd0, state}, 0);
        step();
        check("nom_opening", {29'd0, state}, 1);
        check("nom_j_pulse", {31'd0, j}, 1);
        step();
        check("nom_j_one_cycle", {31'd0, j}, 0);
        step();
        check("nom_watering", {29'd0, state}, 2);
        dry = 1'b0;
        step();
        check("nom_closing", {29'd0, state}, 3);
        check("nom_k_pulse", {31'd0, k}, 1);
        step();
        check("nom_k_one_cycle", {31'd0, k}, 0);
        step();
        check("nom_cooldown", {29'd0, state}, 4);
        repeat (29) do_tick();
        check("nom_cooldown_29", {29'd0, state}, 4);
        do_tick();
        check("nom_idle_30", {29'd0, state}, 0);
        check("nom_j_count", j_cnt - j0, 1);
        check("nom_k_count", k_cnt - k0, 1);

        // max-on time
        j0 = j_cnt;
        dry = 1'b1;
        repeat (3) do_tick();
        step(); step(); step();
        check("max_watering", {29'd0, state}, 2);
        repeat (59) do_tick();
        check("max_tick59", {29'd0, state}, 2);
        do_tick();
        check("max_tick60_closing", {29'd0, state}, 3);
        check("max_k_pulse", {31'd0, k}, 1);
        step(); step();
        check("max_cooldown", {29'd0, state}, 4);
        repeat (30) do_tick();
        check("max_idle", {29'd0, state}, 0);
        repeat (2) do_tick();
        check("max_deb2_idle", {29'd0, state}, 0);
        do_tick();
        check("max_deb3_no_j", {31'd0, j}, 0);
        step();
        check("max_reopen_j", {31'd0, j}, 1);
        check("max_j_count", j_cnt - j0, 1);
        step(); step();
        dry = 1'b0;
        step();
        tick_until("max_back_idle", 3'd0, 40);

        // tank interlock
        j0 = j_cnt;
        dry = 1'b1; tank_low = 1'b1;
        repeat (3) do_tick();
        repeat (5) step();
        check("lock_idle", {29'd0, state}, 0);
        check("lock_no_j", j_cnt - j0, 0);
        tank_low = 1'b0;
        step();
        check("lock_release_j", {31'd0, j}, 1);
        step(); step();
        check("lock_watering", {29'd0, state}, 2);
        tank_low = 1'b1;
        step();
        check("lock_k_next_edge", {31'd0, k}, 1);
        check("lock_closing", {29'd0, state}, 3);
        tank_low = 1'b0; dry = 1'b0;
        step();
        tick_until("lock_back_idle", 3'd0, 40);

        // debounce glitch
        j0 = j_cnt;
        dry = 1'b1;
        repeat (2) do_tick();
        dry = 1'b0;
        do_tick();
        dry = 1'b1;
        repeat (2) do_tick();
        repeat (3) step();
        check("glitch_idle", {29'd0, state}, 0);
        check("glitch_no_j", j_cnt - j0, 0);
        check("jk_exclusive", jk_both, 0);

        // stuck valve
        stuck = 1'b1;
        do_tick();
        check("stuck_pre_idle", {29'd0, state}, 0);
        step();
        check("stuck_j_pulse", {31'd0, j}, 1);
        j0 = j_cnt;
        repeat (7) step();
        check("stuck_opening_7", {29'd0, state}, 1);
        step();
        check("stuck_fault_state_8", {29'd0, state}, 5);
        check("stuck_fault_flag", {31'd0, fault}, 1);
        check("stuck_k_held", {31'd0, k}, 1);
        dry = 1'b0;
        repeat (2) do_tick();
        dry = 1'b1;
        repeat (4) do_tick();
        check("stuck_state_hold", {29'd0, state}, 5);
        check("stuck_fault_hold", {31'd0, fault}, 1);
        check("stuck_k_hold", {31'd0, k}, 1);
        check("stuck_j_low", {31'd0, j}, 0);
        check("stuck_no_new_j", j_cnt - j0, 1);

        // async reset mid-WATERING
        clear_n = 1'b0;
        step();
        check("fault_reset_state", {29'd0, state}, 0);
        stuck = 1'b0;
        clear_n = 1'b1;
        step();
        check("fault_release_no_j", {31'd0, j}, 0);
        repeat (3) do_tick();
        step(); step(); step();
        check("ar_watering", {29'd0, state}, 2);
        #3;
        clear_n = 1'b0;
        #1;
        check("ar_state", {29'd0, state}, 0);
        check("ar_j", {31'd0, j}, 0);
        check("ar_k", {31'd0, k}, 0);
        check("ar_fault", {31'd0, fault}, 0);
        step();
        j0 = j_cnt; k0 = k_cnt;
        clear_n = 1'b1;
        step();
        check("ar_release_state", {29'd0, state}, 0);
        check("ar_release_j", {31'd0, j}, 0);
        check("ar_release_k", {31'd0, k}, 0);
        step();
        check("ar_release_pulses", (j_cnt - j0) + (k_cnt - k0), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/valve_jk_driver.md
VALVE_JK_DRIVER -- requirements
Module: valve_jk_driver

Interface
REQ-001 The block SHALL have parameter DEB_TICKS, default 3: consecutive dry ticks required before watering starts.
REQ-002 The block SHALL have parameter MAX_ON_TICKS, default 60: maximum watering duration in ticks.
REQ-003 The block SHALL have parameter MIN_OFF_TICKS, default 30: minimum rest time in ticks after a close.
REQ-004 The block SHALL have parameter ACK_CYCLES, default 8: clock cycles allowed for valve feedback to follow a command.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port clear_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port tick, input, 1 bit: single-cycle time-base strobe.
REQ-008 The block SHALL have port dry, input, 1 bit: soil-dry sensor, already synchronised.
REQ-009 The block SHALL have port tank_low, input, 1 bit: reservoir-low sensor, already synchronised.
REQ-010 The block SHALL have port q_fb, input, 1 bit: valve state, taken from the downstream JK flip-flop q.
REQ-011 The block SHALL have port j, output, 1 bit: JK set command to the valve flip-flop.
REQ-012 The block SHALL have port k, output, 1 bit: JK reset command to the valve flip-flop.
REQ-013 The block SHALL have port state, output, 3 bits: current FSM state code.
REQ-014 The block SHALL have port fault, output, 1 bit: sticky fault flag.

Function
REQ-015 The j, k, state and fault outputs SHALL be registered, and j and k SHALL never be 1 in the same cycle.
REQ-016 The debounce counter SHALL increment on each tick with dry=1, saturating at DEB_TICKS; a tick with dry=0 SHALL clear it; dry_ok = (count==DEB_TICKS).
REQ-017 State codes SHALL be: IDLE=0, OPENING=1, WATERING=2, CLOSING=3, COOLDOWN=4, FAULT=5; codes 6 and 7 SHALL go to FAULT.
REQ-018 From IDLE, the block SHALL go to OPENING when dry_ok=1 and tank_low=0; if tank_low=1 in the same cycle, it SHALL stay in IDLE.
REQ-019 On entry to OPENING, the block SHALL pulse j=1 for exactly one cycle and clear the ack counter.
REQ-020 In OPENING, q_fb=1 SHALL go to WATERING; otherwise, ACK_CYCLES cycles after entry the block SHALL go to FAULT.
REQ-021 In WATERING, each tick SHALL increment on_cnt (cleared on entry).
REQ-022 From WATERING, the block SHALL go to CLOSING on dry=0, tank_low=1, or on_cnt reaching MAX_ON_TICKS.
REQ-023 In WATERING, q_fb=0 SHALL go to FAULT.
REQ-024 When an exit condition and a tick coincide in WATERING, the exit SHALL win and on_cnt SHALL not increment.
REQ-025 On entry to CLOSING, the block SHALL pulse k=1 for exactly one cycle; q_fb=0 SHALL go to COOLDOWN, and ACK_CYCLES cycles without it SHALL go to FAULT.
REQ-026 In COOLDOWN, the block SHALL count ticks, go to IDLE after MIN_OFF_TICKS, and ignore dry and tank_low.
REQ-027 The debounce counter SHALL be cleared on COOLDOWN exit.
REQ-028 In FAULT, the block SHALL hold fault=1, k=1 and j=0 continuously; FAULT SHALL be left only by reset.
REQ-029 Latency SHALL be: IDLE condition true -> j=1 on the next clock edge; WATERING exit condition -> k=1 on the next edge.

Reset
REQ-030 On clear_n=0, the block SHALL asynchronously force state=IDLE, j=0, k=0, fault=0, and all counters to 0, including mid-OPENING or mid-CLOSING.
REQ-031 Release of clear_n SHALL be synchronous to clk, and no j or k pulse SHALL be issued in the first cycle after release.

Structure
REQ-032 The state codes and parameter defaults SHALL live in shared package valve_pkg.
REQ-033 Debounce logic SHALL be a sub-module, tick_debouncer (ports clk, clear_n, tick, din, ok).
REQ-034 The block SHALL instantiate no JK flip-flop; j and k drive the existing downstream flip-flop externally.

Verification
REQ-035 Scenario, nominal cycle: dry=1 for 3 ticks, bench JK loops q_fb -> j pulse once, state 1->2; dry=0 -> k pulse once, state 3->4; after 30 ticks, state=0.
REQ-036 Scenario, max-on: dry held 1 -> CLOSING entered exactly on the 60th WATERING tick; j pulses again only after 30 COOLDOWN ticks plus 3 debounce ticks.
REQ-037 Scenario, stuck valve: q_fb tied 0 -> state=5 and fault=1 exactly 8 cycles after the j pulse; k=1 is held, and state is held despite dry toggling.
REQ-038 Scenario, interlock: tank_low=1 with dry_ok=1 -> state stays 0 with no j; tank_low rising in WATERING -> k pulse on the next edge.
REQ-039 Scenario, debounce glitch: dry high for 2 ticks, low for 1 tick, high for 2 ticks -> no j pulse.
REQ-040 Scenario, async reset: clear_n=0 mid-WATERING (not clock-aligned) -> state=0, j=k=fault=0 immediately; there is no pulse on release.
